// File: rtl/fetch_sequencer.sv
// fetch_sequencer: issues 2-wide fetch PCs, captures returned pairs and queues them for decode,
// with credit-based flow control, branch redirect flush and sticky halt.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int IQ_DEPTH = 4,
  localparam int AW = $clog2(IQ_DEPTH),
  localparam int OW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [31:0]   pc,
  input  logic [31:0]   inst1,
  input  logic [31:0]   inst2,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  input  logic          halt_req,
  output logic          dec_valid,
  input  logic          dec_ready,
  output logic [31:0]   dec_pc,
  output logic [31:0]   dec_inst1,
  output logic [31:0]   dec_inst2,
  output logic [OW-1:0] occupancy,
  output logic          halted
);
  localparam logic [OW:0] DEPTH = (OW+1)'(IQ_DEPTH);
  logic [31:0] pc_q, pc_d, ifpc_q, ifpc_d;
  logic inflight_q, inflight_d, halt_q, halt_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [31:0] mem_pc [IQ_DEPTH];
  logic [31:0] mem_i1 [IQ_DEPTH];
  logic [31:0] mem_i2 [IQ_DEPTH];
  logic push, pop, issue_ok;
  assign push = inflight_q && !redirect_valid;
  assign dec_valid = occ_q != '0;
  assign pop = dec_valid && dec_ready && !redirect_valid;
  // Credit check counts the pair in flight so a capture never finds the FIFO full.
  assign issue_ok = !halt_q && !halt_req && ({1'b0, occ_q} + {{OW{1'b0}}, inflight_q}) < DEPTH;
  always_comb begin
    pc_d = redirect_valid ? (redirect_pc & ~32'h3) : issue_ok ? pc_q + 32'd8 : pc_q;
    inflight_d = !redirect_valid && issue_ok;
    ifpc_d = issue_ok ? pc_q : ifpc_q;
    halt_d = halt_req || (halt_q && !redirect_valid);
    wr_d = redirect_valid ? '0 : wr_q + AW'(push);
    rd_d = redirect_valid ? '0 : rd_q + AW'(pop);
    occ_d = redirect_valid ? '0 : occ_q + OW'(push) - OW'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      ifpc_q <= '0;
      inflight_q <= 1'b0;
      halt_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      occ_q <= '0;
    end else begin
      pc_q <= pc_d;
      ifpc_q <= ifpc_d;
      inflight_q <= inflight_d;
      halt_q <= halt_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      occ_q <= occ_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_q] <= ifpc_q;
      mem_i1[wr_q] <= inst1;
      mem_i2[wr_q] <= inst2;
    end
  end
  assign pc = pc_q;
  assign occupancy = occ_q;
  assign dec_pc = dec_valid ? mem_pc[rd_q] : '0;
  assign dec_inst1 = dec_valid ? mem_i1[rd_q] : '0;
  assign dec_inst2 = dec_valid ? mem_i2[rd_q] : '0;
  assign halted = halt_q && !dec_valid && !inflight_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: table vectors, directed corner sequences and random stimulus
// checked against a queue-based reference model of the fetch sequencer.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic rst_n, redirect_valid, halt_req, dec_ready;
  logic [31:0] pc, inst1, inst2, redirect_pc, dec_pc, dec_inst1, dec_inst2;
  logic dec_valid, halted;
  logic [2:0] occupancy;
  logic [31:0] fa;
  int tests = 0;
  int fails = 0;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .inst1(inst1), .inst2(inst2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
    .dec_inst1(dec_inst1), .dec_inst2(dec_inst2), .occupancy(occupancy), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h3C00_0000;
  endfunction

  // fetch unit stub: data for the pc sampled at an edge appears after that edge
  always @(posedge clk) fa <= pc;
  assign inst1 = f(fa);
  assign inst2 = f(fa + 32'd4);

  typedef struct { logic [31:0] pc, i1, i2; } pair_t;
  pair_t q[$];
  logic [31:0] m_pc, m_ifpc;
  bit m_if, m_halt;

  task automatic model(input bit r, input bit rv, input logic [31:0] rpc, input bit hr, input bit dr);
    int n;
    bit iss;
    if (!r) begin
      q.delete(); m_pc = 32'h0; m_if = 0; m_halt = 0; m_ifpc = 32'h0;
    end else if (rv) begin
      q.delete(); m_pc = rpc & 32'hFFFF_FFFC; m_if = 0; m_halt = hr;
    end else begin
      n = q.size();
      iss = !m_halt && !hr && (n + int'(m_if)) < 4;
      if (dr && n > 0) void'(q.pop_front());
      if (m_if) q.push_back('{m_ifpc, f(m_ifpc), f(m_ifpc + 32'd4)});
      m_halt = m_halt || hr;
      if (iss) begin m_ifpc = m_pc; m_pc = m_pc + 32'd8; end
      m_if = iss;
    end
  endtask

  function automatic logic [132:0] expv();
    pair_t h = '{32'h0, 32'h0, 32'h0};
    if (q.size() > 0) h = q[0];
    return {m_pc, q.size() > 0, h.pc, h.i1, h.i2, 3'(q.size()), m_halt && q.size() == 0 && !m_if};
  endfunction

  function automatic logic [132:0] actv();
    return {pc, dec_valid, dec_pc, dec_inst1, dec_inst2, occupancy, halted};
  endfunction

  task automatic chk(input string name, input logic [132:0] act, input logic [132:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit rv, input logic [31:0] rpc, input bit hr, input bit dr);
    rst_n = r; redirect_valid = rv; redirect_pc = rpc; halt_req = hr; dec_ready = dr;
    @(posedge clk);
    model(r, rv, rpc, hr, dr);
    @(negedge clk);
    chk("model", actv(), expv());
  endtask

  typedef struct { bit r; bit dr; logic [31:0] pc; bit v; logic [31:0] dpc; logic [2:0] occ; } vec_t;
  vec_t tbl[$];

  initial begin
    logic [31:0] saved;
    rst_n = 0; redirect_valid = 0; redirect_pc = 0; halt_req = 0; dec_ready = 0;
    // streaming from reset, then backpressure saturating the FIFO
    tbl.push_back('{0, 1, 32'h0, 0, 32'h0, 3'd0});
    tbl.push_back('{0, 1, 32'h0, 0, 32'h0, 3'd0});
    tbl.push_back('{1, 1, 32'h8, 0, 32'h0, 3'd0});
    tbl.push_back('{1, 1, 32'h10, 1, 32'h0, 3'd1});
    tbl.push_back('{1, 1, 32'h18, 1, 32'h8, 3'd1});
    tbl.push_back('{1, 1, 32'h20, 1, 32'h10, 3'd1});
    tbl.push_back('{1, 1, 32'h28, 1, 32'h18, 3'd1});
    tbl.push_back('{0, 0, 32'h0, 0, 32'h0, 3'd0});
    tbl.push_back('{1, 0, 32'h8, 0, 32'h0, 3'd0});
    tbl.push_back('{1, 0, 32'h10, 1, 32'h0, 3'd1});
    tbl.push_back('{1, 0, 32'h18, 1, 32'h0, 3'd2});
    tbl.push_back('{1, 0, 32'h20, 1, 32'h0, 3'd3});
    for (int i = 0; i < 6; i++) tbl.push_back('{1, 0, 32'h20, 1, 32'h0, 3'd4});
    tbl.push_back('{1, 1, 32'h20, 1, 32'h8, 3'd3});
    tbl.push_back('{1, 1, 32'h28, 1, 32'h10, 3'd2});
    tbl.push_back('{1, 1, 32'h30, 1, 32'h18, 3'd2});
    tbl.push_back('{1, 1, 32'h38, 1, 32'h20, 3'd2});
    tbl.push_back('{1, 1, 32'h40, 1, 32'h28, 3'd2});
    foreach (tbl[i]) begin
      step(tbl[i].r, 0, 32'h0, 0, tbl[i].dr);
      chk("table", {pc, dec_valid, dec_pc, occupancy, halted},
          {tbl[i].pc, tbl[i].v, tbl[i].dpc, tbl[i].occ, 1'b0});
      if (tbl[i].v) chk("table_inst", {dec_inst1, dec_inst2}, {f(tbl[i].dpc), f(tbl[i].dpc + 32'd4)});
    end
    // redirect with three pairs buffered
    step(1, 0, 32'h0, 0, 0);
    chk("occ_before_redirect", 133'(occupancy), 133'(3));
    step(1, 1, 32'h103, 0, 1);
    chk("redirect_flush", {pc, dec_valid, occupancy}, {32'h100, 1'b0, 3'd0});
    step(1, 0, 32'h0, 0, 1);
    chk("redirect_issue", 133'(pc), 133'(32'h108));
    step(1, 0, 32'h0, 0, 1);
    chk("redirect_first", {dec_valid, dec_pc}, {1'b1, 32'h100});
    // halt with two pairs buffered
    step(1, 0, 32'h0, 0, 0);
    chk("occ_before_halt", 133'(occupancy), 133'(2));
    saved = pc;
    step(1, 0, 32'h0, 1, 1);
    chk("halt_pc_hold", 133'(pc), 133'(saved));
    for (int i = 0; i < 8 && !halted; i++) begin
      step(1, 0, 32'h0, 0, 1);
      chk("halt_pc_hold", 133'(pc), 133'(saved));
    end
    chk("halted", {halted, dec_valid, occupancy}, {1'b1, 1'b0, 3'd0});
    // address wrap
    step(1, 1, 32'hFFFF_FFF8, 0, 1);
    chk("wrap_redirect", {pc, halted}, {32'hFFFF_FFF8, 1'b0});
    step(1, 0, 32'h0, 0, 1);
    chk("wrap_pc", 133'(pc), 133'(32'h0));
    step(1, 0, 32'h0, 0, 1);
    chk("wrap_dec0", {dec_valid, dec_pc}, {1'b1, 32'hFFFF_FFF8});
    step(1, 0, 32'h0, 0, 1);
    chk("wrap_dec1", {dec_valid, dec_pc}, {1'b1, 32'h0});
    // reset mid-stream
    step(1, 0, 32'h0, 0, 0);
    chk("occ_before_reset", 133'(occupancy), 133'(2));
    step(0, 0, 32'h0, 0, 1);
    chk("mid_reset", {dec_valid, pc, halted, occupancy}, {1'b0, 32'h0, 1'b0, 3'd0});
    // random traffic against the model
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 49) != 0, $urandom_range(0, 15) == 0, $urandom,
           $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
